// File: rtl/change_dispenser_if.sv
// Request/actuator bundle between the vending FSM (master) and the
// change dispenser (slave). Clock and reset stay plain ports on the design.
interface change_dispenser_if #(
  parameter int MONEY_W = 4,
  parameter int DRINK_N = 4
);
  // request side
  logic               req_valid;
  logic               req_ready;
  logic [MONEY_W-1:0] req_change;
  logic [DRINK_N-1:0] req_drinks;
  logic               refill;

  // actuator / status side
  logic [DRINK_N-1:0] drink_eject;
  logic               coin5_eject;
  logic               coin1_eject;
  logic               busy;
  logic               done;
  logic [MONEY_W-1:0] paid;
  logic               short_change;

  // vending FSM view
  modport master (
    output req_valid, req_change, req_drinks, refill,
    input  req_ready, drink_eject, coin5_eject, coin1_eject,
           busy, done, paid, short_change
  );

  // dispenser view
  modport slave (
    input  req_valid, req_change, req_drinks, refill,
    output req_ready, drink_eject, coin5_eject, coin1_eject,
           busy, done, paid, short_change
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: accepts one dispense request (change amount + drink mask)
// over valid/ready, then ejects the drinks in ascending slot order followed by
// greedy 5-yuan / 1-yuan coins. Every item is a PULSE_CYC-long eject pulse
// followed by GAP_CYC low cycles; a one-cycle done closes the request.
// Optional feature macro: CHANGE_STOCK_EN -- finite hopper stocks, refill input
// and short_change reporting. Without it the hoppers never run dry, refill is
// ignored and short_change stays 0.
module change_dispenser #(
  parameter int MONEY_W    = 4,
  parameter int DRINK_N    = 4,
  parameter int PULSE_CYC  = 4,
  parameter int GAP_CYC    = 2,
  parameter int COIN5_INIT = 3,
  parameter int COIN1_INIT = 9
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   io_bus
);

  // Down-counter covers both the pulse and the gap phase.
  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRINK,
    S_COIN5,
    S_COIN1,
    S_GAP,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [DRINK_N-1:0] r_drinks;      // drinks still to be ejected
  logic [MONEY_W-1:0] r_rem;         // change still owed
  logic [MONEY_W-1:0] r_paid;
  logic [DRINK_N-1:0] r_drink_eject;
  logic               r_coin5;
  logic               r_coin1;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;

  // ---------------------------------------------------------------------------
  // Next-item selection
  // The same picker serves both the accept cycle (working from the request
  // inputs) and the last gap cycle (working from the latched remainder), so
  // the first pulse can start right on the accept edge with registered ejects.
  // ---------------------------------------------------------------------------
  logic               w_in_idle;
  logic               w_in_gap_end;
  logic               w_launch;
  logic [DRINK_N-1:0] w_src_mask;
  logic [MONEY_W-1:0] w_src_rem;
  logic [DRINK_N-1:0] w_lower;       // any drink bit below this index set
  logic [DRINK_N-1:0] w_first_drink; // lowest set bit of w_src_mask, one-hot
  logic               w_avail5;
  logic               w_avail1;
  logic               w_pick_drink;
  logic               w_pick5;
  logic               w_pick1;
  state_t             w_item_state;

  assign w_in_idle    = (r_state == S_IDLE);
  assign w_in_gap_end = (r_state == S_GAP) && (r_cnt == '0);
  assign w_launch     = (w_in_idle && io_bus.req_valid) || w_in_gap_end;

  assign w_src_mask = w_in_idle ? io_bus.req_drinks : r_drinks;
  assign w_src_rem  = w_in_idle ? io_bus.req_change : r_rem;

  // Prefix-OR chain picks the lowest-index pending drink.
  assign w_lower[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DRINK_N; gi++) begin : g_lower
      assign w_lower[gi] = w_lower[gi-1] | w_src_mask[gi-1];
    end
    for (genvar gi = 0; gi < DRINK_N; gi++) begin : g_first
      assign w_first_drink[gi] = w_src_mask[gi] & ~w_lower[gi];
    end
  endgenerate

`ifdef CHANGE_STOCK_EN
  localparam int STK_MAX = (COIN5_INIT > COIN1_INIT) ? COIN5_INIT : COIN1_INIT;
  localparam int STK_W   = (STK_MAX > 0) ? $clog2(STK_MAX + 1) : 1;

  logic [STK_W-1:0] r_stock5;
  logic [STK_W-1:0] r_stock1;
  logic [STK_W-1:0] w_base5;
  logic [STK_W-1:0] w_base1;
  logic             r_short;

  // A refill seen in IDLE takes effect before a same-cycle request looks at stock.
  assign w_base5  = (w_in_idle && io_bus.refill) ? STK_W'(COIN5_INIT) : r_stock5;
  assign w_base1  = (w_in_idle && io_bus.refill) ? STK_W'(COIN1_INIT) : r_stock1;
  assign w_avail5 = (w_base5 != '0);
  assign w_avail1 = (w_base1 != '0);

  // Hopper stock: refill in IDLE, one coin taken on the edge its pulse starts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stock5 <= STK_W'(COIN5_INIT);
      r_stock1 <= STK_W'(COIN1_INIT);
    end else begin
      r_stock5 <= (w_launch && w_pick5) ? (w_base5 - STK_W'(1)) : w_base5;
      r_stock1 <= (w_launch && w_pick1) ? (w_base1 - STK_W'(1)) : w_base1;
    end
  end
`else
  // Unlimited hoppers: a coin is always available, refill has no effect.
  logic w_unused_refill;
  assign w_unused_refill = io_bus.refill;
  assign w_avail5 = 1'b1;
  assign w_avail1 = 1'b1;
`endif

  assign w_pick_drink = |w_src_mask;
  assign w_pick5 = !w_pick_drink && (w_src_rem >= MONEY_W'(5)) && w_avail5;
  // rem>=5 with an empty 5-yuan hopper falls through to 1-yuan coins here.
  assign w_pick1 = !w_pick_drink && !w_pick5 && (w_src_rem != '0) && w_avail1;

  // Map the picked item onto the state that drives its pulse.
  always_comb begin
    w_item_state = S_DONE;
    if (w_pick_drink) begin
      w_item_state = S_DRINK;
    end else if (w_pick5) begin
      w_item_state = S_COIN5;
    end else if (w_pick1) begin
      w_item_state = S_COIN1;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequencer: accept, pulse, gap, done, with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_drinks      <= '0;
      r_rem         <= '0;
      r_paid        <= '0;
      r_drink_eject <= '0;
      r_coin5       <= 1'b0;
      r_coin1       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ready       <= 1'b1;
`ifdef CHANGE_STOCK_EN
      r_short       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid) begin
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_paid  <= '0;
          end
        end

        S_DRINK, S_COIN5, S_COIN1: begin
          if (r_cnt == '0) begin
            // Last pulse cycle: drop the eject and book the coin value.
            r_state       <= S_GAP;
            r_cnt         <= CNT_W'(GAP_CYC - 1);
            r_drink_eject <= '0;
            r_coin5       <= 1'b0;
            r_coin1       <= 1'b0;
            if (r_state == S_COIN5) begin
              r_rem  <= r_rem - MONEY_W'(5);
              r_paid <= r_paid + MONEY_W'(5);
            end else if (r_state == S_COIN1) begin
              r_rem  <= r_rem - MONEY_W'(1);
              r_paid <= r_paid + MONEY_W'(1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_GAP: begin
          // The final gap cycle is handled by the launch block below.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Start the next item (or finish) on accept or at the end of a gap.
      if (w_launch) begin
        r_state       <= w_item_state;
        r_cnt         <= CNT_W'(PULSE_CYC - 1);
        r_drink_eject <= w_first_drink;
        r_coin5       <= w_pick5;
        r_coin1       <= w_pick1;
        r_drinks      <= w_src_mask & ~w_first_drink;
        r_rem         <= w_src_rem;
        r_done        <= (w_item_state == S_DONE);
`ifdef CHANGE_STOCK_EN
        // Also clears the flag on accept when the request has items to serve.
        r_short       <= (w_item_state == S_DONE) && (w_src_rem != '0);
`endif
      end
    end
  end

  assign io_bus.req_ready   = r_ready;
  assign io_bus.drink_eject = r_drink_eject;
  assign io_bus.coin5_eject = r_coin5;
  assign io_bus.coin1_eject = r_coin1;
  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.paid        = r_paid;
`ifdef CHANGE_STOCK_EN
  assign io_bus.short_change = r_short;
`else
  assign io_bus.short_change = 1'b0;
`endif

endmodule
